// File: rtl/fm_radio_pkg.sv
// Shared definitions for the FM radio audio path: sample width default and
// the stereo output sequencer state encoding.
package fm_radio_pkg;

  localparam int DATA_SIZE_DEFAULT = 32;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE      = 3'd0;
  localparam seq_state_t ST_WAIT_PAIR = 3'd1;
  localparam seq_state_t ST_WRITE_L   = 3'd2;
  localparam seq_state_t ST_WRITE_R   = 3'd3;
  localparam seq_state_t ST_DONE      = 3'd4;

  function automatic logic state_is_busy(input seq_state_t s);
    return (s == ST_WAIT_PAIR) || (s == ST_WRITE_L) || (s == ST_WRITE_R);
  endfunction

endpackage

// File: rtl/skew_watchdog.sv
// Counts consecutive enabled cycles where only one channel FIFO has data and
// raises a sticky error once the run of one-sided cycles reaches LIMIT.
module skew_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic one_sided,
  input  logic clear,
  output logic err
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_reg;
  logic          err_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else if (clear) begin
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else if (enable && one_sided) begin
      // Saturate so a long stall cannot wrap back below the limit.
      if (count_reg != CW'(LIMIT)) count_reg <= count_reg + 1'b1;
      if (count_reg == CW'(LIMIT - 1)) err_reg <= 1'b1;
    end else begin
      count_reg <= '0;
    end
  end

  assign err = err_reg;

endmodule

// File: rtl/stereo_out_sequencer.sv
// Pops matched left/right samples from two FWFT FIFOs and writes them
// interleaved (L then R) into a downstream FIFO for NUM_PAIRS pairs per run.
module stereo_out_sequencer
  import fm_radio_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEFAULT,
  parameter int NUM_PAIRS  = 1000,
  parameter int SKEW_LIMIT = 64,
  localparam int PC_W      = $clog2(NUM_PAIRS + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        left_empty,
  input  logic                        right_empty,
  input  logic signed [DATA_SIZE-1:0] left_dout,
  input  logic signed [DATA_SIZE-1:0] right_dout,
  output logic                        left_rd_en,
  output logic                        right_rd_en,
  input  logic                        out_full,
  output logic                        out_wr_en,
  output logic signed [DATA_SIZE-1:0] out_din,
  output logic                        out_is_right,
  output logic                        busy,
  output logic                        done,
  output logic                        skew_err,
  output logic [PC_W-1:0]             pair_count
);

  seq_state_t                  state_reg, state_next;
  logic signed [DATA_SIZE-1:0] left_reg, right_reg;
  logic [PC_W-1:0]             count_reg;

  logic start_ok, pair_ready, write_ok, last_pair;

  assign start_ok   = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign pair_ready = (state_reg == ST_WAIT_PAIR) && !left_empty && !right_empty;
  assign write_ok   = ((state_reg == ST_WRITE_L) || (state_reg == ST_WRITE_R)) && !out_full;
  assign last_pair  = (count_reg == PC_W'(NUM_PAIRS - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (start) state_next = ST_WAIT_PAIR;
      ST_WAIT_PAIR:     if (pair_ready) state_next = ST_WRITE_L;
      ST_WRITE_L:       if (!out_full) state_next = ST_WRITE_R;
      ST_WRITE_R:       if (!out_full) state_next = last_pair ? ST_DONE : ST_WAIT_PAIR;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      left_reg  <= '0;
      right_reg <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (pair_ready) begin
        left_reg  <= left_dout;
        right_reg <= right_dout;
      end
      if (start_ok) count_reg <= '0;
      else if (write_ok && (state_reg == ST_WRITE_R)) count_reg <= count_reg + 1'b1;
    end
  end

  // Strobes are decoded from state and live flags so a write can never
  // land in a cycle where the downstream FIFO reports full.
  assign left_rd_en  = pair_ready;
  assign right_rd_en = pair_ready;
  assign out_wr_en   = write_ok;

  always_comb begin
    out_din      = '0;
    out_is_right = 1'b0;
    case (state_reg)
      ST_WRITE_L: out_din = left_reg;
      ST_WRITE_R: begin
        out_din      = right_reg;
        out_is_right = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy       = state_is_busy(state_reg);
  assign done       = (state_reg == ST_DONE);
  assign pair_count = count_reg;

  skew_watchdog #(
    .LIMIT(SKEW_LIMIT)
  ) u_skew_watchdog (
    .clock    (clock),
    .reset    (reset),
    .enable   (state_reg == ST_WAIT_PAIR),
    .one_sided(left_empty ^ right_empty),
    .clear    (start_ok),
    .err      (skew_err)
  );

endmodule

// File: tb/tb_stereo_out_sequencer.sv
// Directed bench for stereo_out_sequencer: FWFT FIFO models feed the DUT and
// a scoreboard of expected interleaved samples is drained by the output monitor.
module tb_stereo_out_sequencer;

  localparam int DS  = 32;
  localparam int NP  = 4;
  localparam int SL  = 64;
  localparam int PCW = $clog2(NP + 1);

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 left_empty = 1'b1;
  logic                 right_empty = 1'b1;
  logic signed [DS-1:0] left_dout = '0;
  logic signed [DS-1:0] right_dout = '0;
  logic                 out_full = 1'b0;
  logic                 left_rd_en, right_rd_en, out_wr_en, out_is_right;
  logic                 busy, done, skew_err;
  logic signed [DS-1:0] out_din;
  logic [PCW-1:0]       pair_count;

  always #5 clock = ~clock;

  stereo_out_sequencer #(
    .DATA_SIZE (DS),
    .NUM_PAIRS (NP),
    .SKEW_LIMIT(SL)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .left_empty  (left_empty),
    .right_empty (right_empty),
    .left_dout   (left_dout),
    .right_dout  (right_dout),
    .left_rd_en  (left_rd_en),
    .right_rd_en (right_rd_en),
    .out_full    (out_full),
    .out_wr_en   (out_wr_en),
    .out_din     (out_din),
    .out_is_right(out_is_right),
    .busy        (busy),
    .done        (done),
    .skew_err    (skew_err),
    .pair_count  (pair_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_pop = -1;
  int lpops = 0;
  int rpops = 0;

  logic signed [DS-1:0] lq[$];
  logic signed [DS-1:0] rq[$];
  logic signed [DS-1:0] exp_d[$];
  logic                 exp_r[$];

  logic mon_lp, mon_rp;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DS-1:0] obs, input logic [DS-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  task automatic upd_flags();
    left_empty  = (lq.size() == 0);
    right_empty = (rq.size() == 0);
    left_dout   = (lq.size() != 0) ? lq[0] : '0;
    right_dout  = (rq.size() != 0) ? rq[0] : '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic expect_pair(input int l, input int r);
    exp_d.push_back(DS'(l)); exp_r.push_back(1'b0);
    exp_d.push_back(DS'(r)); exp_r.push_back(1'b1);
  endtask

  task automatic push_pair(input int l, input int r);
    lq.push_back(DS'(l));
    rq.push_back(DS'(r));
    expect_pair(l, r);
    upd_flags();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clock);
      if (done) begin
        at = cyc;
        break;
      end
    end
    check("done_within_budget", 32'(at >= 0), 32'd1);
  endtask

  // Output monitor and FIFO pop model: sample mid-cycle, apply pops after the edge.
  initial begin
    forever begin
      @(negedge clock);
      mon_lp = left_rd_en;
      mon_rp = right_rd_en;
      if (mon_lp && first_pop < 0) first_pop = cyc;
      if (mon_lp || mon_rp) check("rd_en_paired", 32'(right_rd_en), 32'(left_rd_en));
      if (out_wr_en) begin
        check("wr_while_full", 32'(out_full), 32'd0);
        check("write_expected", 32'(exp_d.size() != 0), 32'd1);
        if (exp_d.size() != 0) begin
          check("out_din", out_din, exp_d.pop_front());
          check("out_is_right", 32'(out_is_right), 32'(exp_r.pop_front()));
        end
      end
      @(posedge clock);
      #1;
      if (mon_lp && lq.size() != 0) begin void'(lq.pop_front()); lpops++; end
      if (mon_rp && rq.size() != 0) begin void'(rq.pop_front()); rpops++; end
      upd_flags();
    end
  end

  initial begin
    int at;
    int lp0;
    #1 reset = 1'b0;
    for (int i = 1; i <= 4; i++) push_pair(i, -i);
    tick(); tick();
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_skew_err", 32'(skew_err), 32'd0);
    check("rst_pair_count", 32'(pair_count), 32'd0);
    check("rst_rd_en", 32'(left_rd_en | right_rd_en), 32'd0);
    check("rst_wr_en", 32'(out_wr_en), 32'd0);
    check("rst_out_din", out_din, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("idle_no_pop", 32'(left_rd_en), 32'd0);

    // Basic run: 1,-1,...,4,-4 and 12 cycles from first pop to done.
    tick();
    first_pop = -1;
    pulse_start();
    wait_done(80, at);
    check("done_latency", 32'(at - first_pop), 32'd12);
    check("run1_pair_count", 32'(pair_count), 32'd4);
    check("run1_busy", 32'(busy), 32'd0);
    check("run1_drained", 32'(exp_d.size()), 32'd0);

    // Start while busy is ignored.
    tick();
    for (int i = 0; i < 4; i++) push_pair(100 + i, -(100 + i));
    pulse_start();
    tick();
    tick();
    pulse_start();
    wait_done(80, at);
    check("run2_pair_count", 32'(pair_count), 32'd4);
    check("run2_drained", 32'(exp_d.size()), 32'd0);

    // Start from DONE clears the count and enters a new run.
    tick();
    pulse_start();
    @(negedge clock);
    check("restart_pair_count", 32'(pair_count), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_done", 32'(done), 32'd0);

    // Downstream full held for 5 cycles while the right sample is pending.
    tick();
    push_pair(5, -5);
    tick();
    tick();
    out_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_no_write", 32'(out_wr_en), 32'd0);
      tick();
    end
    out_full = 1'b0;
    @(negedge clock);
    check("stall_release_write", 32'(out_wr_en), 32'd1);
    check("stall_release_right", 32'(out_is_right), 32'd1);
    tick();
    @(negedge clock);
    check("stall_pair_count", 32'(pair_count), 32'd1);
    check("stall_drained", 32'(exp_d.size()), 32'd0);

    // Skew: left only for SL cycles.
    tick();
    lp0 = lpops;
    lq.push_back(DS'(7));
    upd_flags();
    repeat (SL - 1) tick();
    @(negedge clock);
    check("skew_before_limit", 32'(skew_err), 32'd0);
    tick();
    @(negedge clock);
    check("skew_at_limit", 32'(skew_err), 32'd1);
    check("skew_no_left_pop", 32'(lpops - lp0), 32'd0);
    check("skew_still_busy", 32'(busy), 32'd1);
    tick();
    rq.push_back(DS'(-7));
    expect_pair(7, -7);
    upd_flags();
    repeat (4) tick();
    @(negedge clock);
    check("skew_pair_count", 32'(pair_count), 32'd2);
    check("skew_drained", 32'(exp_d.size()), 32'd0);
    check("skew_sticky", 32'(skew_err), 32'd1);

    // Reset during WRITE_L abandons the latched pair.
    tick();
    push_pair(8, -8);
    tick();
    check("pre_reset_din", out_din, DS'(8));
    reset = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(out_wr_en), 32'd0);
    check("mid_rst_out_din", out_din, 32'd0);
    check("mid_rst_is_right", 32'(out_is_right), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_skew_err", 32'(skew_err), 32'd0);
    check("mid_rst_pair_count", 32'(pair_count), 32'd0);
    void'(exp_d.pop_front()); void'(exp_r.pop_front());
    void'(exp_d.pop_front()); void'(exp_r.pop_front());
    tick();
    tick();
    reset = 1'b1;
    tick();
    for (int i = 9; i <= 12; i++) push_pair(i, -i);
    first_pop = -1;
    pulse_start();
    wait_done(80, at);
    check("run3_latency", 32'(at - first_pop), 32'd12);
    check("run3_pair_count", 32'(pair_count), 32'd4);
    check("run3_drained", 32'(exp_d.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
